// File: rtl/param_register_file.sv
// DATA_W x DEPTH register file with two read ports and one write port, an optional
// hardwired-zero entry 0, write-to-read bypass, 0/1-cycle read latency and a clear sweep.
module param_register_file #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_REG0    = 1,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_r;
    logic              wr_ok;
    logic [DATA_W-1:0] rv_1;
    logic [DATA_W-1:0] rv_2;
    logic [DATA_W-1:0] mem [DEPTH];

    // An address names a real, writable/readable entry (not past the end, not the zero entry).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    function automatic logic [DATA_W-1:0] read_rule(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              blocked,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        if (blocked || !addr_ok(a)) begin
            return '0;
        end
        if ((BYPASS != 0) && fwd_en && (fwd_addr == a)) begin
            return fwd_data;
        end
        return stored;
    endfunction

    assign busy  = busy_r;
    assign wr_ok = !busy_r && regwrite && addr_ok(write_reg);

    // Sweep control: reset or a clear request restarts the pointer at entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_r <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        ptr    <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state  <= CLEAR;
                        busy_r <= 1'b1;
                        ptr    <= '0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy_r <= 1'b1;
                    ptr    <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[write_reg] <= write_data;
        end
    end

    // Stage p0: read value selection.
    always_comb begin
        rv_1 = read_rule(read_reg_1, mem[read_reg_1], busy_r, wr_ok, write_reg, write_data);
        rv_2 = read_rule(read_reg_2, mem[read_reg_2], busy_r, wr_ok, write_reg, write_data);
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign read_data_1 = rv_1;
            assign read_data_2 = rv_2;
        end else begin : g_reg_read
            logic [DATA_W-1:0] rd_1_p1;
            logic [DATA_W-1:0] rd_2_p1;

            // Stage p1: registered read data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_1_p1 <= '0;
                    rd_2_p1 <= '0;
                end else begin
                    rd_1_p1 <= rv_1;
                    rd_2_p1 <= rv_2;
                end
            end

            assign read_data_1 = rd_1_p1;
            assign read_data_2 = rd_2_p1;
        end
    endgenerate

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: two configurations driven by shared stimulus and checked
// against a per-cycle reference model of the register file rules.
module tb_param_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          regwrite;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg_1;
    logic [AW-1:0] read_reg_2;
    logic          busy_a, busy_b;
    logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;

    always #5 clk = ~clk;

    param_register_file #(
        .DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .ZERO_REG0(1), .BYPASS(1), .READ_LATENCY(0)
    ) u_a (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_a),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(rd1_a), .read_data_2(rd2_a)
    );

    param_register_file #(
        .DATA_W(DW), .DEPTH(24), .ADDR_W(AW), .ZERO_REG0(1), .BYPASS(0), .READ_LATENCY(1)
    ) u_b (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_b),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(rd1_b), .read_data_2(rd2_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: instance 0 = u_a, instance 1 = u_b.
    int          depth_m [2] = '{32, 24};
    bit          bypass_m[2] = '{1'b1, 1'b0};
    bit          lat_m   [2] = '{1'b0, 1'b1};
    bit          zero_m  [2] = '{1'b1, 1'b1};
    logic [31:0] mem     [2][256];
    int          busy_cnt[2];
    logic [31:0] rdq     [2][2];
    int          run_len [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit accepted(int i);
        int wa = int'(write_reg);
        return (busy_cnt[i] == 0) && regwrite && (wa < depth_m[i]) && !(zero_m[i] && wa == 0);
    endfunction

    function automatic logic [31:0] rule(int i, int addr);
        if (busy_cnt[i] > 0) return 32'h0;
        if (addr >= depth_m[i] || (zero_m[i] && addr == 0)) return 32'h0;
        if (bypass_m[i] && accepted(i) && int'(write_reg) == addr) return write_data;
        return mem[i][addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = depth_m[i];
            rdq[i][0]   = 32'h0;
            rdq[i][1]   = 32'h0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] n1, n2;
        for (int i = 0; i < 2; i++) begin
            n1 = rule(i, int'(read_reg_1));
            n2 = rule(i, int'(read_reg_2));
            if (busy_cnt[i] > 0) begin
                mem[i][depth_m[i] - busy_cnt[i]] = 32'h0;
                busy_cnt[i]--;
            end else begin
                if (accepted(i)) mem[i][int'(write_reg)] = write_data;
                if (clear_req) busy_cnt[i] = depth_m[i];
            end
            rdq[i][0] = n1;
            rdq[i][1] = n2;
        end
    endtask

    // One cycle: drive at the falling edge, compare mid-phase, then advance the model past the rising edge.
    task automatic step(input bit r, input bit c, input bit w, input int wa, input logic [31:0] wd,
                        input int a1, input int a2);
        logic        ob;
        logic [31:0] o1, o2, e1, e2;
        @(negedge clk);
        rst        = r;
        clear_req  = c;
        regwrite   = w;
        write_reg  = AW'(wa);
        write_data = wd;
        read_reg_1 = AW'(a1);
        read_reg_2 = AW'(a2);
        if (r) model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            ob = (i == 0) ? busy_a : busy_b;
            o1 = (i == 0) ? rd1_a : rd1_b;
            o2 = (i == 0) ? rd2_a : rd2_b;
            e1 = lat_m[i] ? rdq[i][0] : rule(i, a1);
            e2 = lat_m[i] ? rdq[i][1] : rule(i, a2);
            check_eq($sformatf("busy[%0d]", i), {31'h0, ob}, {31'h0, busy_cnt[i] > 0});
            check_eq($sformatf("rd1[%0d] a=%0d", i, a1), o1, e1);
            check_eq($sformatf("rd2[%0d] a=%0d", i, a2), o2, e2);
            if (r) begin
                run_len[i] = 0;
            end else if (ob) begin
                run_len[i]++;
            end else if (run_len[i] > 0) begin
                check_eq($sformatf("busy_len[%0d]", i), run_len[i], depth_m[i]);
                run_len[i] = 0;
            end
        end
        if (!r) model_edge();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 32'h0, 1, 2);
    endtask

    initial begin
        rst = 1'b1; clear_req = 1'b0; regwrite = 1'b0;
        write_reg = '0; write_data = '0; read_reg_1 = '0; read_reg_2 = '0;
        run_len = '{0, 0};
        for (int i = 0; i < 2; i++) for (int a = 0; a < 256; a++) mem[i][a] = 32'h0;
        model_reset();

        // Reset then full sweep; every address reads zero afterwards.
        step(1, 0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 32'h0, 0, 0);
        idle(32);
        step(0, 0, 0, 0, 32'h0, 1, 2);
        check_eq("busy_after_sweep", {31'h0, busy_a}, 32'h0);
        for (int a = 0; a < 32; a++) step(0, 0, 0, 0, 32'h0, a, 31 - a);

        // Plain write/read and the hardwired zero entry.
        step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        step(0, 0, 0, 0, 32'h0, 5, 0);
        check_eq("x5_read", rd1_a, 32'hDEADBEEF);
        step(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        check_eq("x0_same", rd1_a, 32'h0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        check_eq("x0_read", rd1_a, 32'h0);

        // Same-cycle bypass vs. no bypass.
        step(0, 0, 1, 7, 32'h1234, 0, 7);
        check_eq("bypass_x7", rd2_a, 32'h1234);
        step(0, 0, 0, 0, 32'h0, 0, 7);
        check_eq("nobypass_x7_old", rd2_b, 32'h0);
        step(0, 0, 0, 0, 32'h0, 0, 7);
        check_eq("nobypass_x7_new", rd2_b, 32'h1234);

        // Clear request; writes during the sweep are dropped.
        step(0, 0, 1, 3, 32'h55, 3, 5);
        step(0, 1, 0, 0, 32'h0, 3, 5);
        for (int k = 0; k < 32; k++) step(0, 0, 1, 3, 32'h55, 3, 5);
        step(0, 0, 0, 0, 32'h0, 3, 5);
        check_eq("x3_cleared", rd1_a, 32'h0);
        check_eq("x5_cleared", rd2_a, 32'h0);

        // Reset in the middle of a sweep restarts it.
        step(0, 1, 0, 0, 32'h0, 1, 2);
        idle(10);
        step(1, 0, 0, 0, 32'h0, 1, 2);
        idle(34);

        // Registered read: visible only after the edge; out-of-range address reads zero.
        step(0, 0, 1, 5, 32'hA5, 1, 2);
        step(0, 0, 0, 0, 32'h0, 5, 2);
        check_eq("lat1_before", rd1_b, 32'h0);
        step(0, 0, 1, 30, 32'h77, 30, 2);
        check_eq("lat1_after", rd1_b, 32'hA5);
        step(0, 0, 0, 0, 32'h0, 30, 2);
        check_eq("lat1_oor", rd1_b, 32'h0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            int wa, a1, a2;
            bit r, c, w;
            r  = ($urandom_range(0, 599) == 0);
            c  = ($urandom_range(0, 79) == 0);
            w  = $urandom_range(0, 1);
            wa = $urandom_range(0, 31);
            a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            a2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            step(r, c, w, wa, $urandom, a1, a2);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
